// File: rtl/detector_arbiter_pkg.sv
// Shared encodings for the two-channel detector arbiter.
package detector_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_CLOSE = 2'b10
   } star_t;

   localparam logic CH0 = 1'b0;
   localparam logic CH1 = 1'b1;

endpackage

// File: rtl/detector_arbiter_rr_pick.sv
// Two-way grant picker: round-robin on ties when rr=1,
// otherwise channel 0 wins every tie.
module detector_arbiter_rr_pick
   import detector_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   input  logic       rr,
   output logic       gnt,
   output logic       any
);

   always_comb begin
      any = |req;
      gnt = CH0;
      unique case (1'b1)
         (req == 2'b11): gnt = rr ? ~last : CH0;
         (req == 2'b10): gnt = CH1;
         default:        gnt = CH0;
      endcase
   end

endmodule

// File: rtl/detector_arbiter.sv
// Round-robin front end sharing one detector datapath between
// two dav_/rfd producers; every output comes straight from a flop.
module detector_arbiter
   import detector_arbiter_pkg::*;
#(
   parameter int SYM_W = 2,
   parameter int RR    = 1
) (
   input  logic             clock,
   input  logic             reset_,
   input  logic             dav0_,
   input  logic [SYM_W-1:0] x0,
   output logic             rfd0,
   input  logic             dav1_,
   input  logic [SYM_W-1:0] x1,
   output logic             rfd1,
   output logic [SYM_W-1:0] sym,
   output logic             step,
   output logic             ch,
   input  logic             ready
);

   star_t            star_q, star_d;
   logic [SYM_W-1:0] sym_q, sym_d;
   logic             ch_q, ch_d;
   logic [1:0]       rfd_q, rfd_d;
   logic             step_q, step_d;
   logic             last_q, last_d;

   logic [1:0] req;
   logic       gnt;
   logic       any;
   logic       dav_ch_n;

   assign req      = {~dav1_ & rfd_q[1], ~dav0_ & rfd_q[0]};
   assign dav_ch_n = ch_q ? dav1_ : dav0_;

   detector_arbiter_rr_pick u_rr_pick (
      .req  (req),
      .last (last_q),
      .rr   (RR != 0),
      .gnt  (gnt),
      .any  (any)
   );

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         star_q <= S_IDLE;
         sym_q  <= '0;
         ch_q   <= CH0;
         rfd_q  <= 2'b11;
         step_q <= 1'b0;
         last_q <= CH1;
      end else begin
         star_q <= star_d;
         sym_q  <= sym_d;
         ch_q   <= ch_d;
         rfd_q  <= rfd_d;
         step_q <= step_d;
         last_q <= last_d;
      end
   end

   always_comb begin
      star_d = S_IDLE;
      unique case (star_q)
         S_IDLE:  star_d = any ? S_ISSUE : S_IDLE;
         S_ISSUE: star_d = ready ? S_CLOSE : S_ISSUE;
         S_CLOSE: star_d = dav_ch_n ? S_IDLE : S_CLOSE;
         default: star_d = S_IDLE;
      endcase
   end

   always_comb begin
      sym_d  = sym_q;
      ch_d   = ch_q;
      rfd_d  = rfd_q;
      step_d = 1'b0;
      last_d = last_q;
      unique case (star_q)
         S_IDLE: begin
            if (any) begin
               sym_d      = gnt ? x1 : x0;
               ch_d       = gnt;
               rfd_d[gnt] = 1'b0;
               last_d     = gnt;
            end
         end
         S_ISSUE: step_d = ready;
         S_CLOSE: begin
            if (dav_ch_n) rfd_d[ch_q] = 1'b1;
         end
         default: begin
            sym_d  = '0;
            ch_d   = CH0;
            rfd_d  = 2'b11;
            last_d = CH1;
         end
      endcase
   end

   assign rfd0 = rfd_q[0];
   assign rfd1 = rfd_q[1];
   assign sym  = sym_q;
   assign step = step_q;
   assign ch   = ch_q;

endmodule

// File: tb/tb_detector_arbiter.sv
// Scoreboard bench: a round-robin instance and a fixed-priority
// instance, expected {ch,sym} per step queued ahead of time.
module tb_detector_arbiter;

   logic       clock;
   logic       reset_;
   logic       ready;
   logic       dav_n [4];
   logic [1:0] xs [4];
   logic [3:0] rfd;
   logic [1:0] stp;
   logic [1:0] chs;
   logic [1:0] sym_r;
   logic [1:0] sym_f;

   logic       auto_on [4];
   int         cnt [4];
   logic [2:0] q_rr [$];
   logic [2:0] q_fp [$];
   int         n_vec;
   int         n_err;

   detector_arbiter #(.SYM_W(2), .RR(1)) u_rr (
      .clock  (clock),
      .reset_ (reset_),
      .dav0_  (dav_n[0]),
      .x0     (xs[0]),
      .rfd0   (rfd[0]),
      .dav1_  (dav_n[1]),
      .x1     (xs[1]),
      .rfd1   (rfd[1]),
      .sym    (sym_r),
      .step   (stp[0]),
      .ch     (chs[0]),
      .ready  (ready)
   );

   detector_arbiter #(.SYM_W(2), .RR(0)) u_fp (
      .clock  (clock),
      .reset_ (reset_),
      .dav0_  (dav_n[2]),
      .x0     (xs[2]),
      .rfd0   (rfd[2]),
      .dav1_  (dav_n[3]),
      .x1     (xs[3]),
      .rfd1   (rfd[3]),
      .sym    (sym_f),
      .step   (stp[1]),
      .ch     (chs[1]),
      .ready  (ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, got, exp);
      end
   endtask

   always @(negedge clock) begin
      logic [2:0] e;
      if (stp[0]) begin
         if (q_rr.size() == 0) begin
            chk("rr_extra_step", {1'b1, chs[0], sym_r}, 0);
         end else begin
            e = q_rr.pop_front();
            chk("rr_step", {chs[0], sym_r}, e);
         end
      end
      if (stp[1]) begin
         if (q_fp.size() == 0) begin
            chk("fp_extra_step", {1'b1, chs[1], sym_f}, 0);
         end else begin
            e = q_fp.pop_front();
            chk("fp_step", {chs[1], sym_f}, e);
         end
      end
   end

   // Auto producers drop dav_ once their step is seen, re-request while cnt>0.
   task automatic cyc();
      @(posedge clock);
      #1;
      for (int k = 0; k < 4; k++) begin
         if (auto_on[k]) begin
            if (!dav_n[k] && !rfd[k]) begin
               if (stp[k>>1] && chs[k>>1] == k[0]) dav_n[k] = 1'b1;
            end else if (dav_n[k] && rfd[k] && cnt[k] > 0) begin
               dav_n[k] = 1'b0;
               cnt[k]--;
            end
         end
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 80; i++) begin
         if (q_rr.size() == 0 && q_fp.size() == 0) break;
         cyc();
      end
      chk(tag, q_rr.size() + q_fp.size(), 0);
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_rr"}, {rfd[1:0], stp[0], chs[0], sym_r}, 6'b110000);
      chk({tag, "_fp"}, {rfd[3:2], stp[1], chs[1], sym_f}, 6'b110000);
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      reset_ = 1'b1;
      ready  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         dav_n[k]   = 1'b1;
         xs[k]      = 2'b00;
         auto_on[k] = 1'b0;
         cnt[k]     = 0;
      end
      #1 reset_ = 1'b0;
      #1 chk_rst("reset");
      cyc();
      cyc();
      reset_ = 1'b1;
      cyc();
      chk_rst("idle_after_reset");

      // single request on channel 0
      xs[0]    = 2'b10;
      dav_n[0] = 1'b0;
      q_rr.push_back({1'b0, 2'b10});
      cyc();
      chk("t1_rfd_taken", {rfd[1:0], stp[0]}, 3'b100);
      cyc();
      chk("t1_step", {stp[0], chs[0], sym_r}, 4'b1010);
      cyc();
      chk("t1_step_one_clk", {stp[0], rfd[0]}, 2'b00);
      dav_n[0] = 1'b1;
      cyc();
      chk("t1_rfd_back", rfd[1:0], 2'b11);
      drain("t1_drain");

      // both channels requesting from reset release, round-robin
      reset_   = 1'b0;
      xs[0]    = 2'b01;
      xs[1]    = 2'b11;
      dav_n[0] = 1'b0;
      dav_n[1] = 1'b0;
      cnt[0]   = 3;
      cnt[1]   = 3;
      auto_on[0] = 1'b1;
      auto_on[1] = 1'b1;
      for (int i = 0; i < 8; i++)
         q_rr.push_back({i[0], i[0] ? 2'b11 : 2'b01});
      cyc();
      reset_ = 1'b1;
      drain("t2_alternate");
      cyc();
      cyc();
      cyc();
      chk("t2_idle", {rfd[1:0], dav_n[0], dav_n[1]}, 4'b1111);
      auto_on[0] = 1'b0;
      auto_on[1] = 1'b0;

      // back-pressure on channel 1; x1 changes after the latch edge
      ready    = 1'b0;
      xs[1]    = 2'b01;
      dav_n[1] = 1'b0;
      q_rr.push_back({1'b1, 2'b01});
      cyc();
      chk("t3_grant", rfd[1:0], 2'b01);
      xs[1] = 2'b10;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("t3_hold", {stp[0], chs[0], sym_r}, 4'b0101);
      end
      ready = 1'b1;
      cyc();
      chk("t3_step", {stp[0], chs[0], sym_r}, 4'b1101);
      dav_n[1] = 1'b1;
      cyc();
      chk("t3_close", {stp[0], rfd[1:0]}, 3'b011);
      drain("t3_drain");

      // slow producer on channel 1 stalls channel 0
      xs[1]    = 2'b11;
      dav_n[1] = 1'b0;
      q_rr.push_back({1'b1, 2'b11});
      cyc();
      xs[0]    = 2'b00;
      dav_n[0] = 1'b0;
      cyc();
      chk("t4_step", {stp[0], chs[0]}, 2'b11);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t4_stall", {stp[0], rfd[1:0]}, 3'b001);
      end
      q_rr.push_back({1'b0, 2'b00});
      dav_n[1] = 1'b1;
      cyc();
      chk("t4_release", rfd[1:0], 2'b11);
      cyc();
      chk("t4_grant0", rfd[1:0], 2'b10);
      cyc();
      dav_n[0] = 1'b1;
      cyc();
      cyc();
      drain("t4_drain");

      // asynchronous reset while a step is pending
      ready    = 1'b0;
      xs[0]    = 2'b11;
      dav_n[0] = 1'b0;
      cyc();
      chk("t5_grant", rfd[1:0], 2'b10);
      cyc();
      #2 reset_ = 1'b0;
      #1 chk_rst("t5_async");
      ready = 1'b1;
      cyc();
      cyc();
      chk_rst("t5_held");
      q_rr.push_back({1'b0, 2'b11});
      reset_ = 1'b1;
      cyc();
      chk("t5_regrant", rfd[1:0], 2'b10);
      cyc();
      dav_n[0] = 1'b1;
      cyc();
      cyc();
      drain("t5_drain");

      // fixed priority instance: channel 1 waits for channel 0 to stop
      xs[2]    = 2'b10;
      xs[3]    = 2'b01;
      dav_n[2] = 1'b0;
      dav_n[3] = 1'b0;
      cnt[2]   = 2;
      cnt[3]   = 0;
      auto_on[2] = 1'b1;
      auto_on[3] = 1'b1;
      for (int i = 0; i < 3; i++) q_fp.push_back({1'b0, 2'b10});
      q_fp.push_back({1'b1, 2'b01});
      drain("t6_fixed");
      cyc();
      cyc();
      cyc();
      chk("t6_idle", {rfd[3:2], dav_n[2], dav_n[3]}, 4'b1111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
